y86_imem_encoder: RTL and testbench

- Writer-side counterpart of the SEQ fetch stage. Fetch decodes instruction bytes into fields; this block does the reverse.
- It accepts decoded Y86-64 instruction fields (icode, ifun, rA, rB, valC) over a valid/ready handshake.
- It serialises each instruction into its canonical byte encoding and writes it, one byte per cycle, into the instruction memory's byte write port at an auto-advancing write pointer.
- Used to load programs into instruction memory for simulation and bring-up.

---
 rtl/y86_imem_encoder_if.sv | 32 +++
 rtl/y86_imem_encoder.sv | 148 ++++++++++++++
 tb/tb_y86_imem_encoder.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/y86_imem_encoder_if.sv
// Bundle of signals between a program loader and the Y86-64 instruction-memory encoder.
// The slave side is the encoder. The master side supplies instruction fields and observes the memory write port.
interface y86_imem_encoder_if #(
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       icode;
  logic [3:0]       ifun;
  logic [3:0]       rA;
  logic [3:0]       rB;
  logic [63:0]      valC;
  logic             ptr_load;
  logic [63:0]      load_addr;
  logic             mem_we;
  logic [63:0]      mem_addr;
  logic [7:0]       mem_wdata;
  logic [63:0]      wr_ptr;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output in_valid, icode, ifun, rA, rB, valC, ptr_load, load_addr,
    input  in_ready, mem_we, mem_addr, mem_wdata, wr_ptr, busy, err, instr_count
  );

  modport slave (
    input  in_valid, icode, ifun, rA, rB, valC, ptr_load, load_addr,
    output in_ready, mem_we, mem_addr, mem_wdata, wr_ptr, busy, err, instr_count
  );
endinterface

// File: rtl/y86_imem_encoder.sv
// Serialises decoded Y86-64 instruction fields into canonical bytes.
// The bytes are written one per cycle into instruction memory at an auto-advancing pointer.
module y86_imem_encoder #(
  parameter int MEM_BYTES = 1024,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  y86_imem_encoder_if.slave  bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q;
  logic             mem_we_q;
  logic [63:0]      mem_addr_q;
  logic [7:0]       mem_wdata_q;
  logic [63:0]      wr_ptr_q;
  logic             busy_q;
  logic             err_q;
  logic [CNT_W-1:0] instr_count_q;
  logic [71:0]      rest_q;   // bytes still to be presented, lowest first
  logic [3:0]       len_q;
  logic [3:0]       idx_q;
  logic [63:0]      start_q;

  logic [79:0]      enc_d;
  logic [3:0]       len_d;
  logic             legal_d;
  logic [64:0]      end_d;
  logic             fits_d;
  logic             hs_d;

  always_comb begin
    enc_d         = '0;
    enc_d[7:0]    = {bus.icode, bus.ifun};
    len_d         = 4'd0;
    legal_d       = 1'b0;
    case (bus.icode)
      4'h0, 4'h1, 4'h9: begin
        len_d   = 4'd1;
        legal_d = (bus.ifun == 4'd0);
      end
      4'h2: begin
        len_d       = 4'd2;
        legal_d     = (bus.ifun <= 4'd6);
        enc_d[15:8] = {bus.rA, bus.rB};
      end
      4'h3: begin
        len_d        = 4'd10;
        legal_d      = (bus.ifun == 4'd0);
        enc_d[15:8]  = {4'hF, bus.rB};
        enc_d[79:16] = bus.valC;
      end
      4'h4, 4'h5: begin
        len_d        = 4'd10;
        legal_d      = (bus.ifun == 4'd0);
        enc_d[15:8]  = {bus.rA, bus.rB};
        enc_d[79:16] = bus.valC;
      end
      4'h6: begin
        len_d       = 4'd2;
        legal_d     = (bus.ifun <= 4'd3);
        enc_d[15:8] = {bus.rA, bus.rB};
      end
      4'h7, 4'h8: begin
        len_d       = 4'd9;
        legal_d     = (bus.icode == 4'h8) ? (bus.ifun == 4'd0) : (bus.ifun <= 4'd6);
        enc_d[71:8] = bus.valC;
      end
      4'hA, 4'hB: begin
        len_d       = 4'd2;
        legal_d     = (bus.ifun == 4'd0);
        enc_d[15:8] = {bus.rA, 4'hF};
      end
      default: ;
    endcase
    // 65-bit sum so a pointer near 2^64 cannot wrap past the bound.
    end_d  = {1'b0, wr_ptr_q} + {61'd0, len_d};
    fits_d = (end_d <= 65'(MEM_BYTES));
    hs_d   = bus.in_valid & bus.in_ready;
  end

  assign bus.in_ready    = rst_n & (state_q == IDLE) & ~bus.ptr_load;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.wr_ptr      = wr_ptr_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;
  assign bus.instr_count = instr_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      wr_ptr_q      <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      instr_count_q <= '0;
      rest_q        <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      start_q       <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ptr_load) begin
            wr_ptr_q <= bus.load_addr;
          end else if (hs_d) begin
            if (legal_d && fits_d) begin
              state_q     <= EMIT;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= wr_ptr_q;
              mem_wdata_q <= enc_d[7:0];
              rest_q      <= enc_d[79:8];
              len_q       <= len_d;
              idx_q       <= 4'd0;
              start_q     <= wr_ptr_q;
              busy_q      <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (idx_q == len_q - 4'd1) begin
            state_q       <= IDLE;
            mem_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            wr_ptr_q      <= start_q + {60'd0, len_q};
            instr_count_q <= instr_count_q + CNT_W'(1);
          end else begin
            idx_q       <= idx_q + 4'd1;
            mem_addr_q  <= mem_addr_q + 64'd1;
            mem_wdata_q <= rest_q[7:0];
            rest_q      <= {8'h00, rest_q[71:8]};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_imem_encoder.sv
// Scoreboard bench for y86_imem_encoder: directed scenarios plus randomized instructions,
// all checked against a byte-list reference model.
module tb_y86_imem_encoder;
  localparam int MEM_BYTES = 1024;
  localparam int CNT_W     = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  y86_imem_encoder_if #(.CNT_W(CNT_W)) bus ();

  y86_imem_encoder #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit              is_err;
    longint unsigned cyc;
    logic [63:0]     addr;
    logic [7:0]      data;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [7:0]       ref_bytes[$];
  int               vectors = 0;
  int               miscompares = 0;
  longint unsigned  cyc = 0;
  logic [63:0]      m_ptr = '0;
  logic [CNT_W-1:0] m_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int ref_maxfun(input logic [3:0] ic);
    if (ic == 4'h2 || ic == 4'h7) return 6;
    if (ic == 4'h6) return 3;
    return 0;
  endfunction

  function automatic bit ref_legal(input logic [3:0] ic, input logic [3:0] fn);
    if (ic > 4'hB) return 1'b0;
    return int'(fn) <= ref_maxfun(ic);
  endfunction

  // Canonical byte list for one instruction, built from the encoding table.
  function automatic void ref_encode(input logic [3:0] ic, input logic [3:0] fn,
                                     input logic [3:0] ra, input logic [3:0] rb,
                                     input logic [63:0] vc);
    logic [63:0] v;
    ref_bytes.delete();
    ref_bytes.push_back({ic, fn});
    if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB})
      ref_bytes.push_back({(ic == 4'h3) ? 4'hF : ra,
                           (ic == 4'hA || ic == 4'hB) ? 4'hF : rb});
    if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) begin
      v = vc;
      for (int i = 0; i < 8; i++) begin
        ref_bytes.push_back(v[7:0]);
        v = v >> 8;
      end
    end
  endfunction

  // Monitor: every write or error pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1 || bus.err === 1'b1) begin
      vectors++;
      if (bus.mem_we === 1'b1 && bus.err === 1'b1) begin
        miscompares++;
        $display("FAIL err_with_we: got err=1 with mem_we=1, want err=0 (cycle %0d)", cyc);
      end
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got we=%0b err=%0b addr=0x%0h data=0x%0h, want nothing (cycle %0d)",
                 bus.mem_we, bus.err, bus.mem_addr, bus.mem_wdata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_is_err", 64'(bus.err), 64'(mon_e.is_err));
        chk("out_cycle", cyc, mon_e.cyc);
        if (!mon_e.is_err) begin
          chk("mem_addr", bus.mem_addr, mon_e.addr);
          chk("mem_wdata", 64'(bus.mem_wdata), 64'(mon_e.data));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc, input bit hold,
                      output longint unsigned c0);
    bit ok;
    int len;
    bus.icode = ic; bus.ifun = fn; bus.rA = ra; bus.rB = rb; bus.valC = vc;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 40; w++) begin
      #1;
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    c0 = cyc;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: got in_ready=0 for 40 cycles, want 1");
      bus.in_valid = 1'b0;
      return;
    end
    ref_encode(ic, fn, ra, rb, vc);
    len = ref_bytes.size();
    if (ref_legal(ic, fn) && (({1'b0, m_ptr} + 65'(len)) <= 65'(MEM_BYTES))) begin
      for (int k = 0; k < len; k++)
        exp_q.push_back('{1'b0, c0 + 1 + longint'(k), m_ptr + 64'(k), ref_bytes[k]});
      $display("instr icode=%h ifun=%h at 0x%0h len=%0d accepted", ic, fn, m_ptr, len);
      m_ptr = m_ptr + 64'(len);
      m_cnt = m_cnt + 1;
    end else begin
      exp_q.push_back('{1'b1, c0 + 1, 64'd0, 8'd0});
      $display("instr icode=%h ifun=%h at 0x%0h rejected", ic, fn, m_ptr);
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 40; w++) begin
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: got busy=1 for 40 cycles, want 0");
    end
  endtask

  task automatic check_state();
    chk("wr_ptr", bus.wr_ptr, m_ptr);
    chk("instr_count", 64'(bus.instr_count), 64'(m_cnt));
  endtask

  task automatic load_ptr(input logic [63:0] a);
    bus.ptr_load = 1'b1;
    bus.load_addr = a;
    #1 chk("in_ready_during_load", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.ptr_load = 1'b0;
    m_ptr = a;
    chk("wr_ptr_after_load", bus.wr_ptr, a);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = '0;
    m_cnt = '0;
  endtask

  initial begin
    longint unsigned c1, c2, c3, c4;
    logic [3:0] ic, fn;
    bus.in_valid = 1'b0; bus.icode = '0; bus.ifun = '0; bus.rA = '0; bus.rB = '0;
    bus.valC = '0; bus.ptr_load = 1'b0; bus.load_addr = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_wr_ptr", bus.wr_ptr, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_instr_count", 64'(bus.instr_count), 64'd0);
    rst_n = 1'b1;
    #1 chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // irmovq: 30 F3 EF CD AB 89 67 45 23 01
    send(4'h3, 4'h0, 4'h0, 4'h3, 64'h0123456789ABCDEF, 1'b0, c1);
    wait_idle();
    chk("irmovq_wr_ptr", bus.wr_ptr, 64'd10);
    chk("irmovq_count", 64'(bus.instr_count), 64'd1);

    // Back-to-back stream with in_valid held high.
    pulse_reset();
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0, 1'b1, c1);
    send(4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 1'b1, c2);
    chk("gap_after_nop", c2 - c1, 64'd2);
    send(4'h7, 4'h0, 4'h0, 4'h0, 64'h100, 1'b1, c3);
    chk("gap_after_addq", c3 - c2, 64'd3);
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, c4);
    chk("gap_after_jmp", c4 - c3, 64'd10);
    wait_idle();
    chk("stream_wr_ptr", bus.wr_ptr, 64'd13);
    chk("stream_count", 64'(bus.instr_count), 64'd4);

    // Pointer load takes priority over a pending pushq.
    bus.icode = 4'hA; bus.ifun = 4'h0; bus.rA = 4'h5; bus.rB = 4'h0; bus.in_valid = 1'b1;
    load_ptr(64'h200);
    send(4'hA, 4'h0, 4'h5, 4'h0, 64'd0, 1'b0, c1);
    wait_idle();
    chk("pushq_wr_ptr", bus.wr_ptr, 64'h202);

    // Illegal instructions are rejected without moving the pointer.
    load_ptr(64'h10);
    send(4'hC, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, c1);
    wait_idle();
    chk("bad_icode_wr_ptr", bus.wr_ptr, 64'h10);
    send(4'h6, 4'h4, 4'h1, 4'h2, 64'd0, 1'b0, c1);
    wait_idle();
    chk("bad_ifun_wr_ptr", bus.wr_ptr, 64'h10);
    check_state();

    // Bounds at the top of memory.
    load_ptr(64'd1020);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h55, 1'b0, c1);
    wait_idle();
    chk("bounds_reject_wr_ptr", bus.wr_ptr, 64'd1020);
    send(4'h9, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, c1);
    wait_idle();
    chk("ret_wr_ptr", bus.wr_ptr, 64'd1021);

    // Reset in the middle of a call, after its fourth byte.
    load_ptr(64'h40);
    send(4'h8, 4'h0, 4'h0, 4'h0, 64'h1122334455667788, 1'b0, c1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_ptr = '0;
    m_cnt = '0;
    @(negedge clk);
    chk("midrst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("midrst_wr_ptr", bus.wr_ptr, 64'd0);
    chk("midrst_count", 64'(bus.instr_count), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, c1);
    wait_idle();
    chk("nop_after_rst_wr_ptr", bus.wr_ptr, 64'd1);

    // Randomized instructions, with occasional pointer loads near the top of memory.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        wait_idle();
        check_state();
        if ($urandom_range(0, 1) == 1) load_ptr(64'($urandom_range(0, 900)));
        else load_ptr(64'(MEM_BYTES - int'($urandom_range(0, 12))));
      end
      ic = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 11));
      fn = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, ref_maxfun(ic)));
      send(ic, fn, 4'($urandom), 4'($urandom), {$urandom, $urandom}, 1'b0, c1);
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        check_state();
      end
    end
    wait_idle();
    check_state();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion after 50000 cycles, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
